avalon_arbiter_2to1: RTL and testbench

Two-to-one Avalon-MM arbiter sharing a single memory host port between the core's instruction-fetch and data-access hosts. It accepts commands from both requesters, grants one per transfer using round-robin priority, and forwards the granted command unchanged to memory. An in-order tag FIFO records the requester of every outstanding pipelined read so each `readdatavalid` beat returns to the correct requester. It sits between the core's two `AvalonMmRw.Host` ports and the memory/bus `AvalonMmRw.Agent`.

---
 rtl/avalon_arbiter_2to1.sv | 152 +++++++++++++++
 tb/tb_avalon_arbiter_2to1.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter_2to1.sv
// rtl/avalon_arbiter_2to1.sv - round-robin 2:1 Avalon-MM arbiter with in-order read tag FIFO
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ifetch_*            requester 0 (instruction fetch), agent side
//   dmem_*              requester 1 (data access), agent side
//   mem_*               shared downstream host port
//   err_spurious        sticky: readdatavalid seen with no read outstanding
module avalon_arbiter_2to1 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] ifetch_address,
  input  logic [3:0]  ifetch_byteenable,
  input  logic        ifetch_read,
  input  logic        ifetch_write,
  input  logic [31:0] ifetch_host_to_agent,
  output logic        ifetch_waitrequest,
  output logic [31:0] ifetch_agent_to_host,
  output logic        ifetch_readdatavalid,

  input  logic [31:0] dmem_address,
  input  logic [3:0]  dmem_byteenable,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_host_to_agent,
  output logic        dmem_waitrequest,
  output logic [31:0] dmem_agent_to_host,
  output logic        dmem_readdatavalid,

  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_host_to_agent,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_agent_to_host,
  input  logic        mem_readdatavalid,

  output logic        err_spurious
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic                       last_winner;
  logic                       lock;
  logic                       grant_q;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [MAX_OUTSTANDING-1:0] tags;

  logic req0;
  logic req1;
  logic grant;
  logic g_read;
  logic g_write;
  logic full;
  logic fifo_empty;
  logic grant_wait;
  logic accepted;
  logic push;
  logic pop;
  logic head_id;

  assign req0 = ifetch_read | ifetch_write;
  assign req1 = dmem_read | dmem_write;

  // While locked the previous grant is held so a stalled command cannot be
  // pre-empted; otherwise a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    if (lock)
      grant = grant_q;
    else if (req0 && req1)
      grant = ~last_winner;
    else if (req1)
      grant = 1'b1;
  end

  assign g_read  = grant ? dmem_read  : ifetch_read;
  assign g_write = grant ? dmem_write : ifetch_write;

  // Fullness uses the registered count, so a pop in the same cycle does not
  // let a new read through.
  assign full       = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  assign mem_read          = !reset && g_read && !full;
  assign mem_write         = !reset && g_write;
  assign mem_address       = grant ? dmem_address         : ifetch_address;
  assign mem_byteenable    = grant ? dmem_byteenable      : ifetch_byteenable;
  assign mem_host_to_agent = grant ? dmem_host_to_agent   : ifetch_host_to_agent;

  assign grant_wait         = reset || (g_read && full) || mem_waitrequest;
  assign ifetch_waitrequest = grant ? 1'b1 : grant_wait;
  assign dmem_waitrequest   = grant ? grant_wait : 1'b1;

  assign accepted = (mem_read || mem_write) && !mem_waitrequest;
  assign push     = accepted && mem_read;
  assign pop      = mem_readdatavalid && !fifo_empty && !reset;
  assign head_id  = tags[rd_ptr];

  assign ifetch_agent_to_host = mem_agent_to_host;
  assign dmem_agent_to_host   = mem_agent_to_host;
  assign ifetch_readdatavalid = pop && !head_id;
  assign dmem_readdatavalid   = pop && head_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner  <= 1'b1;
      lock         <= 1'b0;
      grant_q      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_spurious <= 1'b0;
    end else begin
      grant_q <= grant;
      if (accepted) begin
        last_winner <= grant;
        lock        <= 1'b0;
      end else if ((mem_read || mem_write) && mem_waitrequest) begin
        lock <= 1'b1;
      end

      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (mem_readdatavalid && fifo_empty)
        err_spurious <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (!reset && push)
      tags[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_avalon_arbiter_2to1.sv
// tb/tb_avalon_arbiter_2to1.sv - self-checking bench for avalon_arbiter_2to1
module tb_avalon_arbiter_2to1;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifetch_address, dmem_address, mem_address;
  logic [3:0]  ifetch_byteenable, dmem_byteenable, mem_byteenable;
  logic        ifetch_read, ifetch_write, dmem_read, dmem_write, mem_read, mem_write;
  logic [31:0] ifetch_host_to_agent, dmem_host_to_agent, mem_host_to_agent;
  logic        ifetch_waitrequest, dmem_waitrequest, mem_waitrequest;
  logic [31:0] ifetch_agent_to_host, dmem_agent_to_host, mem_agent_to_host;
  logic        ifetch_readdatavalid, dmem_readdatavalid, mem_readdatavalid;
  logic        err_spurious;

  always #5 clk = ~clk;

  avalon_arbiter_2to1 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .ifetch_address(ifetch_address), .ifetch_byteenable(ifetch_byteenable),
    .ifetch_read(ifetch_read), .ifetch_write(ifetch_write),
    .ifetch_host_to_agent(ifetch_host_to_agent), .ifetch_waitrequest(ifetch_waitrequest),
    .ifetch_agent_to_host(ifetch_agent_to_host), .ifetch_readdatavalid(ifetch_readdatavalid),
    .dmem_address(dmem_address), .dmem_byteenable(dmem_byteenable),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_host_to_agent(dmem_host_to_agent), .dmem_waitrequest(dmem_waitrequest),
    .dmem_agent_to_host(dmem_agent_to_host), .dmem_readdatavalid(dmem_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_host_to_agent(mem_host_to_agent), .mem_waitrequest(mem_waitrequest),
    .mem_agent_to_host(mem_agent_to_host), .mem_readdatavalid(mem_readdatavalid),
    .err_spurious(err_spurious)
  );

  int tests = 0;
  int fails = 0;

  // Pending command per requester (0 = ifetch, 1 = dmem), held until accepted.
  bit          p_valid [2];
  bit          p_read  [2];
  logic [31:0] p_addr  [2];
  logic [3:0]  p_be    [2];
  logic [31:0] p_data  [2];
  bit          wait_in;
  bit          rdv_in;
  logic [31:0] rdv_data;

  // Reference state: requester IDs of outstanding reads in issue order.
  int tag_q [$];
  bit locked_m;
  int owner_m;
  int last_m;
  bit err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    ifetch_read          = p_valid[0] && p_read[0];
    ifetch_write         = p_valid[0] && !p_read[0];
    ifetch_address       = p_addr[0];
    ifetch_byteenable    = p_be[0];
    ifetch_host_to_agent = p_data[0];
    dmem_read            = p_valid[1] && p_read[1];
    dmem_write           = p_valid[1] && !p_read[1];
    dmem_address         = p_addr[1];
    dmem_byteenable      = p_be[1];
    dmem_host_to_agent   = p_data[1];
    mem_waitrequest      = wait_in;
    mem_readdatavalid    = rdv_in;
    mem_agent_to_host    = rdv_data;
  endtask

  task automatic set_cmd(input int i, input bit rd, input logic [31:0] addr);
    p_valid[i] = 1'b1;
    p_read[i]  = rd;
    p_addr[i]  = addr;
    p_be[i]    = 4'hF;
    p_data[i]  = addr ^ 32'h5A5A_0000;
  endtask

  // One clock: drive, check combinational outputs against the model, clock,
  // then advance the model.
  task automatic cycle();
    int w;
    bit full, exp_rd, exp_wr, pres, exp_rdv0, exp_rdv1, had;
    logic wr_obs;
    apply();
    #1;
    w = -1;
    exp_rd = 0;
    exp_wr = 0;
    had = tag_q.size() > 0;
    full = tag_q.size() == MAXO;
    if (reset) begin
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      if (p_valid[0]) check("rst_ifetch_wait", ifetch_waitrequest, 1);
      if (p_valid[1]) check("rst_dmem_wait", dmem_waitrequest, 1);
    end else begin
      if (locked_m) w = owner_m;
      else if (p_valid[0] && p_valid[1]) w = 1 - last_m;
      else if (p_valid[0]) w = 0;
      else if (p_valid[1]) w = 1;
      if (w >= 0) begin
        exp_rd = p_read[w] && !full;
        exp_wr = !p_read[w];
      end
      check("mem_read", mem_read, exp_rd);
      check("mem_write", mem_write, exp_wr);
      if (exp_rd || exp_wr) begin
        check("mem_address", mem_address, p_addr[w]);
        check("mem_byteenable", mem_byteenable, p_be[w]);
        if (exp_wr) check("mem_wdata", mem_host_to_agent, p_data[w]);
      end
      for (int i = 0; i < 2; i++) begin
        if (p_valid[i]) begin
          wr_obs = (i == 0) ? ifetch_waitrequest : dmem_waitrequest;
          check(i == 0 ? "ifetch_wait" : "dmem_wait", wr_obs,
                (i == w) ? (wait_in || (p_read[i] && full)) : 1'b1);
        end
      end
      exp_rdv0 = rdv_in && had && tag_q[0] == 0;
      exp_rdv1 = rdv_in && had && tag_q[0] == 1;
      check("ifetch_rdv", ifetch_readdatavalid, exp_rdv0);
      check("dmem_rdv", dmem_readdatavalid, exp_rdv1);
      if (exp_rdv0) check("ifetch_rdata", ifetch_agent_to_host, rdv_data);
      if (exp_rdv1) check("dmem_rdata", dmem_agent_to_host, rdv_data);
      check("err_spurious", err_spurious, err_m);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      tag_q.delete();
      locked_m = 0;
      last_m = 1;
      err_m = 0;
    end else begin
      if (rdv_in) begin
        if (had) void'(tag_q.pop_front());
        else err_m = 1;
      end
      pres = exp_rd || exp_wr;
      if (pres && !wait_in) begin
        last_m = w;
        locked_m = 0;
        if (exp_rd) tag_q.push_back(w);
        p_valid[w] = 0;
      end else if (pres && wait_in) begin
        locked_m = 1;
        owner_m = w;
      end
    end
    rdv_in = 0;
    rdv_data = $urandom;
  endtask

  task automatic drain();
    wait_in = 0;
    for (int k = 0; k < 20 && tag_q.size() > 0; k++) begin
      rdv_in = 1;
      cycle();
    end
    check("drained", tag_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    wait_in = 0;
    rdv_in = 0;
    rdv_data = 0;
    last_m = 1;
    locked_m = 0;
    owner_m = 0;
    err_m = 0;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 0; p_read[i] = 0; p_addr[i] = 0; p_be[i] = 0; p_data[i] = 0;
    end

    // Reset with both requesting: nothing forwarded, both stalled.
    set_cmd(0, 1, 32'h10);
    set_cmd(1, 1, 32'h20);
    cycle();
    do_reset();
    check("reset_err", err_spurious, 0);
    p_valid[0] = 0;
    p_valid[1] = 0;
    do_reset();

    // Contention after reset: ifetch wins first tie, then strict alternation.
    for (int c = 0; c < 8; c++) begin
      if (!p_valid[0]) set_cmd(0, 1, 32'h1000 + c);
      if (!p_valid[1]) set_cmd(1, 1, 32'h2000 + c);
      if (tag_q.size() >= 2) rdv_in = 1;
      cycle();
    end
    p_valid[0] = 0;
    p_valid[1] = 0;
    drain();

    // Single requester read returning 0xDEADBEEF two cycles later.
    set_cmd(0, 1, 32'h100);
    cycle();
    cycle();
    rdv_in = 1;
    rdv_data = 32'hDEADBEEF;
    cycle();

    // Lock: dmem write stalled 3 cycles while ifetch waits behind it.
    set_cmd(0, 1, 32'h300);
    cycle();
    set_cmd(0, 1, 32'h304);
    set_cmd(1, 0, 32'h200);
    wait_in = 1;
    for (int c = 0; c < 3; c++) cycle();
    wait_in = 0;
    cycle();
    cycle();
    drain();

    // Throttle: 5 reads with responses withheld; 5th waits for a pop.
    for (int c = 0; c < 6; c++) begin
      if (!p_valid[0]) set_cmd(0, 1, 32'h400 + 4 * c);
      cycle();
    end
    check("throttle_blocked", mem_read, 0);
    rdv_in = 1;
    cycle();
    cycle();
    check("throttle_released", p_valid[0], 0);
    drain();

    // Spurious response is dropped and sticky until reset.
    rdv_in = 1;
    cycle();
    for (int c = 0; c < 3; c++) cycle();
    check("spurious_sticky", err_spurious, 1);
    do_reset();

    // Reset with 3 reads outstanding: later response is spurious.
    for (int c = 0; c < 3; c++) begin
      set_cmd(0, 1, 32'h500 + 4 * c);
      cycle();
    end
    do_reset();
    rdv_in = 1;
    cycle();
    set_cmd(0, 1, 32'h600);
    cycle();
    rdv_in = 1;
    cycle();
    cycle();
    check("post_reset_err", err_spurious, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && ($urandom % 3 == 0)) begin
          p_valid[i] = 1;
          p_read[i]  = $urandom % 2;
          p_addr[i]  = $urandom;
          p_be[i]    = 4'($urandom);
          p_data[i]  = $urandom;
        end
      end
      wait_in = ($urandom % 4 == 0);
      rdv_in  = (tag_q.size() > 0) && ($urandom % 3 != 0);
      cycle();
    end
    p_valid[0] = 0;
    p_valid[1] = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
